// File: rtl/serial_paralelo.sv
// serial_paralelo: serial-to-parallel receiver with COM-symbol byte alignment.
// Hunts bit by bit for the COM idle symbol, confirms alignment with a run of
// LOCK_COUNT COMs on byte boundaries, then delivers every non-COM byte.
// Ports:
//   clk_32f   - bit clock, one serial bit per rising edge
//   reset     - asynchronous, active-high
//   in_serial - serial data, MSB first
//   data_out  - last received data byte
//   valid_out - high for the byte period of each delivered data byte
//   active    - link locked, sticky until reset
module serial_paralelo #(
    parameter logic [7:0]  COM        = 8'hBC,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       in_serial,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned COM_W  = 4;

    typedef enum logic [1:0] {
        SEARCH,
        LOCK,
        ACTIVE
    } state_t;

    state_t              state, state_n;
    // Only the seven most recent bits are ever needed to form the next byte.
    logic [BYTE_W-2:0]   sr;
    logic [BYTE_W-1:0]   nxt;
    logic [BIT_W-1:0]    bit_cnt, bit_cnt_n;
    logic [COM_W-1:0]    com_cnt, com_cnt_n, com_sat;
    logic [BYTE_W-1:0]   data_n;
    logic                valid_n;
    logic                active_n;
    logic                boundary;
    logic                is_com;

    // Byte that is complete after the current edge, and boundary detection.
    always_comb begin
        nxt      = {sr, in_serial};
        boundary = (bit_cnt == BIT_W'(7));
        is_com   = (nxt == COM);
        // Incremented COM run, saturating at LOCK_COUNT.
        if (com_cnt >= COM_W'(LOCK_COUNT)) begin
            com_sat = COM_W'(LOCK_COUNT);
        end else begin
            com_sat = com_cnt + COM_W'(1);
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt + BIT_W'(1);
        com_cnt_n = com_cnt;
        data_n    = data_out;
        valid_n   = valid_out;
        active_n  = active;

        unique case (state)
            SEARCH: begin
                // Bit-level hunt: any edge may complete a COM.
                if (is_com) begin
                    bit_cnt_n = '0;
                    com_cnt_n = COM_W'(1);
                    state_n   = LOCK;
                end
            end
            LOCK: begin
                if (boundary) begin
                    if (is_com) begin
                        com_cnt_n = com_sat;
                        if (com_sat == COM_W'(LOCK_COUNT)) begin
                            state_n  = ACTIVE;
                            active_n = 1'b1;
                        end
                    end else begin
                        // Straddling false match or broken run: hunt again.
                        com_cnt_n = '0;
                        state_n   = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                if (boundary) begin
                    if (is_com) begin
                        valid_n = 1'b0;
                    end else begin
                        data_n  = nxt;
                        valid_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = SEARCH;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state     <= SEARCH;
            sr        <= '0;
            bit_cnt   <= '0;
            com_cnt   <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            active    <= 1'b0;
        end else begin
            state     <= state_n;
            sr        <= nxt[BYTE_W-2:0];
            bit_cnt   <= bit_cnt_n;
            com_cnt   <= com_cnt_n;
            data_out  <= data_n;
            valid_out <= valid_n;
            active    <= active_n;
        end
    end

endmodule

// File: tb/tb_serial_paralelo.sv
// Testbench for serial_paralelo: directed link scenarios plus randomized
// traffic, every output compared each bit against a byte-level reference.
module tb_serial_paralelo;

    localparam logic [7:0] COM        = 8'hBC;
    localparam int         LOCK_COUNT = 4;

    logic       clk_32f = 1'b0;
    logic       reset;
    logic       in_serial;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: bit history window, alignment anchor, COM run length.
    logic [7:0] m_win;
    int         m_phase;     // 0 hunting, 1 counting COMs, 2 locked
    int         m_edge;
    int         m_anchor;
    int         m_run;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_active;

    serial_paralelo #(
        .COM        (COM),
        .LOCK_COUNT (LOCK_COUNT)
    ) dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .in_serial (in_serial),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_win    = 8'h00;
        m_phase  = 0;
        m_edge   = 0;
        m_anchor = 0;
        m_run    = 0;
        m_data   = 8'h00;
        m_valid  = 1'b0;
        m_active = 1'b0;
    endtask

    // One received bit: byte boundaries are every 8th edge after the anchor COM.
    task automatic model_step(input logic b);
        m_edge++;
        m_win = {m_win[6:0], b};
        if (m_phase == 0) begin
            if (m_win == COM) begin
                m_phase  = 1;
                m_anchor = m_edge;
                m_run    = 1;
            end
        end else if ((m_edge - m_anchor) % 8 == 0) begin
            if (m_phase == 1) begin
                if (m_win == COM) begin
                    m_run++;
                    if (m_run == LOCK_COUNT) begin
                        m_phase  = 2;
                        m_active = 1'b1;
                    end
                end else begin
                    m_phase = 0;
                end
            end else begin
                if (m_win != COM) begin
                    m_data  = m_win;
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    endtask

    task automatic check_model();
        check8("model_data", data_out, m_data);
        check8("model_valid", 8'(valid_out), 8'(m_valid));
        check8("model_active", 8'(active), 8'(m_active));
    endtask

    task automatic send_bit(input logic b);
        in_serial = b;
        @(posedge clk_32f);
        model_step(b);
        #1;
        check_model();
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    // Hold reset with random serial activity; outputs must stay cleared.
    task automatic hold_reset(input int cycles);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < cycles; i++) begin
            in_serial = 1'($urandom);
            @(posedge clk_32f);
            #1;
            check8("rst_data", data_out, 8'h00);
            check8("rst_valid", 8'(valid_out), 8'h00);
            check8("rst_active", 8'(active), 8'h00);
        end
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] v;
        int         njunk;

        reset     = 1'b1;
        in_serial = 1'b0;
        model_reset();

        // Reset state under random input
        hold_reset(12);

        // Nominal lock and delivery
        for (int i = 0; i < 3; i++) send_byte(COM);
        check8("nom_pre_lock", 8'(active), 8'h00);
        send_byte(COM);
        check8("nom_lock", 8'(active), 8'h01);
        send_byte(8'hAB);
        check8("nom_ab", data_out, 8'hAB);
        send_byte(8'hCA);
        check8("nom_ca", data_out, 8'hCA);
        send_byte(8'h12);
        check8("nom_12", data_out, 8'h12);
        check8("nom_12_v", 8'(valid_out), 8'h01);
        send_byte(COM);
        check8("nom_com_v", 8'(valid_out), 8'h00);
        check8("nom_com_hold", data_out, 8'h12);
        send_byte(8'hFA);
        check8("nom_fa", data_out, 8'hFA);
        send_byte(8'h33);
        check8("nom_33", data_out, 8'h33);

        // Idle in ACTIVE
        for (int i = 0; i < 3; i++) send_byte(COM);
        check8("idle_valid", 8'(valid_out), 8'h00);
        check8("idle_active", 8'(active), 8'h01);
        check8("idle_hold", data_out, 8'h33);

        // Misaligned start
        hold_reset(3);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        for (int i = 0; i < 4; i++) send_byte(COM);
        check8("mis_lock", 8'(active), 8'h01);
        v = 8'h5A;
        for (int i = 7; i >= 1; i--) send_bit(v[i]);
        check8("mis_early_v", 8'(valid_out), 8'h00);
        send_bit(v[0]);
        check8("mis_data", data_out, 8'h5A);
        check8("mis_valid", 8'(valid_out), 8'h01);

        // Broken lock
        hold_reset(3);
        send_byte(COM);
        send_byte(COM);
        send_byte(8'h55);
        check8("brk_active", 8'(active), 8'h00);
        check8("brk_no55", 8'(valid_out), 8'h00);
        for (int i = 0; i < 4; i++) send_byte(COM);
        check8("brk_relock", 8'(active), 8'h01);
        send_byte(8'hA5);
        check8("brk_a5", data_out, 8'hA5);
        check8("brk_a5_v", 8'(valid_out), 8'h01);

        // Reset mid-operation, inside byte CA
        hold_reset(3);
        for (int i = 0; i < 4; i++) send_byte(COM);
        send_byte(8'hAB);
        v = 8'hCA;
        for (int i = 7; i >= 4; i--) send_bit(v[i]);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check8("mid_rst_data", data_out, 8'h00);
        check8("mid_rst_valid", 8'(valid_out), 8'h00);
        check8("mid_rst_active", 8'(active), 8'h00);
        @(posedge clk_32f);
        #1;
        reset = 1'b0;
        for (int i = 3; i >= 0; i--) send_bit(v[i]);
        for (int i = 0; i < 3; i++) send_byte(COM);
        check8("mid_no_lock", 8'(active), 8'h00);
        send_byte(COM);
        check8("mid_relock", 8'(active), 8'h01);

        // Randomized traffic: random junk prefix, lock run, mixed data/COM bytes
        for (int t = 0; t < 4; t++) begin
            hold_reset(2);
            njunk = int'($urandom_range(0, 7));
            for (int i = 0; i < njunk; i++) send_bit(1'($urandom));
            for (int i = 0; i < LOCK_COUNT; i++) send_byte(COM);
            for (int i = 0; i < 24; i++) begin
                if ($urandom_range(0, 7) == 0) v = COM;
                else v = 8'($urandom);
                send_byte(v);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_paralelo.md
# serial_paralelo

Serial-to-parallel receiver: the far end of the parallel-to-serial link. It takes the MSB-first bit stream on `clk_32f`, finds byte alignment using the COM idle symbol (8'hBC) that the transmitter sends while its `valid_in` is low, and locks after consecutive COMs. Once locked, it delivers each non-COM byte as an 8-bit word with a valid strobe. It is the receive half of the parallel↔serial pair in the datapath.

## Interface
- `COM`, 8'hBC: idle/alignment symbol; must be nonzero.
- `LOCK_COUNT`, 4: consecutive aligned COM bytes required to enter ACTIVE; range 2–15.
- `clk_32f`  in  1: bit clock, one serial bit per rising edge. This is the block's only clock.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `in_serial`  in  1: serial data, MSB first, sampled on the `clk_32f` rising edge.
- `data_out`  out  8: last received data byte.
- `valid_out`  out  1: high for exactly one byte period (8 `clk_32f` cycles) per delivered data byte.
- `active`  out  1: link locked; high from lock until reset.

## Operation
- Shift register `sr` on every edge: `sr <= {sr[6:0], in_serial}`. Define `nxt = {sr[6:0], in_serial}`.
- 3-bit bit counter `bit_cnt`. A byte boundary is the edge where `bit_cnt == 7`; at that edge `nxt` is the complete byte.
- FSM states: SEARCH, LOCK, ACTIVE.
- **SEARCH**
  - `nxt` is compared against `COM` on every edge, ignoring `bit_cnt`.
  - On a match: `bit_cnt <= 0` (the next boundary is 8 edges later), `com_cnt <= 1`, go to LOCK.
  - Outputs stay idle.
- **LOCK**
  - At each boundary: if `nxt == COM`, then `com_cnt <= com_cnt + 1`.
  - When the incremented count equals `LOCK_COUNT`, go to ACTIVE and set `active <= 1` at that same edge.
  - If `nxt != COM`, then `com_cnt <= 0` and go back to SEARCH. Bit-level search resumes on the next edge.
- **ACTIVE**
  - At each boundary: if `nxt != COM`, then `data_out <= nxt` and `valid_out <= 1`.
  - If `nxt == COM`, then `valid_out <= 0` and `data_out` holds its value.
  - Between boundaries all outputs hold.
  - ACTIVE is sticky: only `reset` leaves it. There is no loss-of-lock detection.
- `com_cnt` is 4 bits wide and saturates at `LOCK_COUNT`.

## Timing
- Reset values:
  - `data_out` = 8'h00, `valid_out` = 0, `active` = 0.
  - State = SEARCH; `sr`, `bit_cnt`, `com_cnt` = 0.
- Reset asserted mid-byte clears everything on the reset edge itself, not on a clock edge. After release, alignment restarts from SEARCH.
- Latency: outputs update at the same edge that samples the byte's LSB. No extra pipeline stage.
- Minimum lock time from the first COM bit: `8*LOCK_COUNT` edges. The first data byte can appear at the next boundary after lock.
- Back-to-back data bytes keep `valid_out` continuously high, and `data_out` changes every 8 edges.
- Because `sr` resets to 0 and `COM` is nonzero, SEARCH cannot match on the reset-fill value.
- A false COM match in SEARCH (bit pattern straddling a byte) is rejected by LOCK on the next boundary.

## Test plan
- **Reset:** hold `reset=1` and toggle `in_serial` randomly → `data_out=8'h00`, `valid_out=0`, `active=0` throughout.
- **Nominal:** after reset, send BC×4, then AB, CA, 12, BC, FA, 33.
  - `active` rises at the LSB edge of the 4th BC.
  - `valid_out`/`data_out` give AB, CA, 12 for 8 cycles each.
  - During the BC slot, `valid_out=0` and `data_out` holds 8'h12.
  - Then FA, then 33.
- **Misaligned start:** send 3 junk bits (1,0,1), then BC×4, then 8'h5A → lock occurs; `data_out=8'h5A` with `valid_out=1` exactly 8 edges after `active` rises.
- **Broken lock:** send BC, BC, 8'h55, then BC×4, then 8'hA5.
  - `active` stays 0 through the first three bytes.
  - Lock occurs after the second BC run.
  - 8'h55 is never output; 8'hA5 is output.
- **Reset mid-operation:** in ACTIVE, assert `reset` between boundaries of byte CA → outputs clear immediately. After release, `active` stays 0 until a fresh run of 4 BCs.
- **Idle in ACTIVE:** after lock, send BC×3 → `valid_out=0`, `active=1`, and `data_out` holds the last data byte.
